multicast_tx: RTL and testbench

Global-buffer-side transmitter for the multicast bus. It takes one host command (destination tag, data type, base address, length) and reads that many words from the global buffer SRAM. It broadcasts each word on the multicast bus with the tag and the matching write-enable line, honouring the bus ready/enable handshake. Every PE-side multicast controller whose ID equals the tag latches the stream; this block is the sending end of that interface.

---
 rtl/multicast_tx.sv | 186 ++++++++++++++++++
 tb/tb_multicast_tx.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicast_tx.sv
// multicast_tx: global-buffer side sender for the multicast bus.
// Accepts one host command, reads cmd_len words from the global buffer SRAM
// starting at cmd_addr and broadcasts them in address order with the command
// tag and the write-enable line matching the data type.
module multicast_tx #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [TAG_W-1:0]  cmd_tag,
  input  logic [1:0]        cmd_type,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              buf_en,
  output logic [ADDR_W-1:0] buf_addr,
  input  logic [DATA_W-1:0] buf_rdata,
  output logic [TAG_W-1:0]  Tag_to_Bus,
  output logic [DATA_W-1:0] value_to_Bus,
  output logic              Enable_to_Bus,
  input  logic              Ready_from_Bus,
  output logic              weight_wea_to_Bus,
  output logic              ifmap_wea_to_Bus,
  output logic              psum_wea_to_Bus,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [1:0] TYPE_WEIGHT  = 2'd0;
  localparam logic [1:0] TYPE_IFMAP   = 2'd1;
  localparam logic [1:0] TYPE_PSUM    = 2'd2;
  localparam logic [1:0] TYPE_ILLEGAL = 2'd3;

  state_t              state;

  // Command fields captured at acceptance; they stay put for the whole transfer.
  logic [TAG_W-1:0]    tag_q;
  logic [1:0]          type_q;
  logic [ADDR_W-1:0]   base_q;
  logic [LEN_W-1:0]    len_q;

  // issued counts SRAM reads, sent counts completed bus handshakes.
  logic [LEN_W-1:0]    issued;
  logic [LEN_W-1:0]    sent;

  // A read issued last cycle has its data on buf_rdata this cycle.
  logic                inflight;

  // Two-entry output buffer between the SRAM and the bus.
  logic [DATA_W-1:0]   fifo_mem [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          fifo_count;

  logic                accept;
  logic                push;
  logic                pop;
  logic [2:0]          occupancy;
  logic                read_fire;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;

  assign Enable_to_Bus = (fifo_count != 2'd0);
  assign value_to_Bus  = fifo_mem[rd_ptr];
  assign Tag_to_Bus    = tag_q;

  assign push = inflight;
  assign pop  = Enable_to_Bus && Ready_from_Bus;

  // Words that will be held or arriving once this cycle ends; a new read is
  // only safe if its data will still find a free slot next cycle.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign read_fire = (state == STREAM) && (issued != len_q) && (occupancy < 3'd2);

  assign buf_en   = read_fire;
  assign buf_addr = base_q + ADDR_W'(issued);

  assign weight_wea_to_Bus = Enable_to_Bus && (type_q == TYPE_WEIGHT);
  assign ifmap_wea_to_Bus  = Enable_to_Bus && (type_q == TYPE_IFMAP);
  assign psum_wea_to_Bus   = Enable_to_Bus && (type_q == TYPE_PSUM);

  assign busy = (state == STREAM) || (state == DRAIN);
  assign done = (state == FINISH);
  assign err  = (state == FINISH) && (type_q == TYPE_ILLEGAL);

  // Control FSM: accept a command, stream reads, wait for the last handshake, report.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      tag_q  <= '0;
      type_q <= '0;
      base_q <= '0;
      len_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            tag_q  <= cmd_tag;
            type_q <= cmd_type;
            base_q <= cmd_addr;
            len_q  <= cmd_len;
            if ((cmd_len == '0) || (cmd_type == TYPE_ILLEGAL)) begin
              state <= FINISH;
            end else begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (read_fire && ((issued + LEN_W'(1)) == len_q)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && ((sent + LEN_W'(1)) == len_q)) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Read and handshake counters, restarted by every accepted command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued <= '0;
      sent   <= '0;
    end else if (accept) begin
      issued <= '0;
      sent   <= '0;
    end else begin
      if (read_fire) begin
        issued <= issued + LEN_W'(1);
      end
      if (pop) begin
        sent <= sent + LEN_W'(1);
      end
    end
  end

  // SRAM return tracking and the two-entry buffer; reset drops any pending read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight    <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      inflight <= read_fire;
      if (push) begin
        fifo_mem[wr_ptr] <= buf_rdata;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_multicast_tx.sv
// Self-checking bench for multicast_tx: a table of commands with hand-computed
// completion cycles, plus hand-written reset-abort and back-to-back sequences.
module tb_multicast_tx;

   localparam int DATA_W = 32;
   localparam int TAG_W  = 6;
   localparam int ADDR_W = 10;
   localparam int LEN_W  = 8;

   localparam int MODE_FULL  = 0;
   localparam int MODE_RAND  = 1;
   localparam int MODE_STALL = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [TAG_W-1:0]  cmd_tag;
   logic [1:0]        cmd_type;
   logic [ADDR_W-1:0] cmd_addr;
   logic [LEN_W-1:0]  cmd_len;
   logic              buf_en;
   logic [ADDR_W-1:0] buf_addr;
   logic [DATA_W-1:0] buf_rdata = '0;
   logic [TAG_W-1:0]  Tag_to_Bus;
   logic [DATA_W-1:0] value_to_Bus;
   logic              Enable_to_Bus;
   logic              Ready_from_Bus;
   logic              weight_wea_to_Bus;
   logic              ifmap_wea_to_Bus;
   logic              psum_wea_to_Bus;
   logic              busy;
   logic              done;
   logic              err;

   wire [2:0] weaBits = {psum_wea_to_Bus, ifmap_wea_to_Bus, weight_wea_to_Bus};

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   multicast_tx #(
      .DATA_W(DATA_W), .TAG_W(TAG_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_tag(cmd_tag), .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .buf_en(buf_en), .buf_addr(buf_addr), .buf_rdata(buf_rdata),
      .Tag_to_Bus(Tag_to_Bus), .value_to_Bus(value_to_Bus),
      .Enable_to_Bus(Enable_to_Bus), .Ready_from_Bus(Ready_from_Bus),
      .weight_wea_to_Bus(weight_wea_to_Bus), .ifmap_wea_to_Bus(ifmap_wea_to_Bus),
      .psum_wea_to_Bus(psum_wea_to_Bus),
      .busy(busy), .done(done), .err(err)
   );

   // Global buffer model: word at address a holds a+1, read data appears the cycle after buf_en.
   logic [DATA_W-1:0] mem [1024];
   always @(posedge clk) begin
      if (buf_en) buf_rdata <= mem[buf_addr];
   end

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] rxValue [$];
   logic [TAG_W-1:0]  rxTag [$];
   logic [2:0]        rxWea [$];
   int readsIssued = 0;
   int popped = 0;
   int donePulses = 0;
   int errPulses = 0;

   logic              prevHold = 1'b0;
   logic [DATA_W-1:0] prevValue = '0;
   logic [TAG_W-1:0]  prevTag = '0;
   logic [2:0]        prevWea = '0;

   typedef struct {
      logic [TAG_W-1:0]  tag;
      logic [1:0]        ctype;
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
      int                mode;
      int                expDoneAt;
      logic              expErr;
   } vec_t;

   vec_t vecs [7];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
      end
   endtask

   // Bus monitor on the falling edge: records each word that will be handshaken
   // at the next rising edge, checks that a stalled word stays frozen, that the
   // wea lines are quiet when nothing is offered, and that reads never run more
   // than two words ahead of the bus while it is stalled.
   always @(negedge clk) begin
      if (!rst) begin
         if (buf_en) readsIssued++;
         if (!Ready_from_Bus) begin
            checks++;
            if (readsIssued - popped > 2) begin
               errors++;
               $display("[TB] FAIL outstanding_reads actual=%0d required<=2", readsIssued - popped);
            end
         end
         if (prevHold) begin
            checkOutput("hold_enable", Enable_to_Bus, 1);
            checkOutput("hold_value", value_to_Bus, prevValue);
            checkOutput("hold_tag", Tag_to_Bus, prevTag);
            checkOutput("hold_wea", weaBits, prevWea);
         end
         if (!Enable_to_Bus) checkOutput("wea_idle", weaBits, 0);
         if (Enable_to_Bus && Ready_from_Bus) begin
            rxValue.push_back(value_to_Bus);
            rxTag.push_back(Tag_to_Bus);
            rxWea.push_back(weaBits);
            popped++;
         end
         if (done) donePulses++;
         if (err) errPulses++;
         prevHold  = Enable_to_Bus && !Ready_from_Bus;
         prevValue = value_to_Bus;
         prevTag   = Tag_to_Bus;
         prevWea   = weaBits;
      end else begin
         prevHold = 1'b0;
      end
   end

   // Offer a command and return just after the edge that accepted it (cycle t=0).
   task automatic applyStimulus(input logic [TAG_W-1:0] tag, input logic [1:0] ctype,
                                input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                                input bit keepValid, output int waited);
      bit acc;
      acc = 1'b0;
      waited = 0;
      rxValue.delete();
      rxTag.delete();
      rxWea.delete();
      readsIssued = 0;
      popped = 0;
      donePulses = 0;
      errPulses = 0;
      cmd_tag = tag;
      cmd_type = ctype;
      cmd_addr = addr;
      cmd_len = len;
      cmd_valid = 1'b1;
      while (!acc && waited < 50) begin
         @(negedge clk);
         if (cmd_ready) acc = 1'b1;
         else waited++;
         @(posedge clk);
         #1;
      end
      if (!keepValid) cmd_valid = 1'b0;
      checks++;
      if (!acc) begin
         errors++;
         $display("[TB] FAIL accept_timeout actual=%0d required<50", waited);
      end
   endtask

   // Drive Ready_from_Bus per mode until done, then compare the delivered stream.
   task automatic checkTransfer(input logic [TAG_W-1:0] tag, input logic [1:0] ctype,
                                input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                                input int mode, input int expDoneAt, input logic expErr);
      int expWords;
      int doneAt;
      expWords = (ctype == 2'd3) ? 0 : int'(len);
      doneAt = -1;
      for (int t = 0; t < 600; t++) begin
         if (t == 0) begin
            checkOutput("tag_latched", Tag_to_Bus, tag);
            checkOutput("busy_after_accept", busy, expWords > 0);
            if (expWords > 0) begin
               checkOutput("first_buf_en", buf_en, 1);
               checkOutput("first_buf_addr", buf_addr, addr);
            end
         end
         if (t == 1) checkOutput("no_early_enable", Enable_to_Bus, 0);
         if (t == 2 && mode == MODE_FULL && expWords > 0) checkOutput("enable_at_e2", Enable_to_Bus, 1);
         checkOutput("cmd_ready_while_active", cmd_ready, 0);
         if (done) begin
            doneAt = t;
            break;
         end
         case (mode)
            MODE_RAND:  Ready_from_Bus = 1'($urandom_range(0, 1));
            MODE_STALL: Ready_from_Bus = !(t >= 6 && t <= 25);
            default:    Ready_from_Bus = 1'b1;
         endcase
         @(posedge clk);
         #1;
      end
      checks++;
      if (doneAt < 0) begin
         errors++;
         $display("[TB] FAIL done_timeout actual=none required=done within 600 cycles");
      end else begin
         if (expDoneAt >= 0) checkOutput("done_cycle", doneAt, expDoneAt);
         checkOutput("err_at_done", err, expErr);
      end
      Ready_from_Bus = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("done_one_cycle", done, 0);
      checkOutput("cmd_ready_after_done", cmd_ready, 1);
      checkOutput("busy_after_done", busy, 0);
      checkOutput("done_pulses", donePulses, 1);
      checkOutput("err_pulses", errPulses, expErr);
      checkOutput("word_count", rxValue.size(), expWords);
      checkOutput("read_count", readsIssued, expWords);
      for (int i = 0; i < rxValue.size() && i < expWords; i++) begin
         checkOutput("word_value", rxValue[i], ((int'(addr) + i) % 1024) + 1);
         checkOutput("word_tag", rxTag[i], tag);
         checkOutput("word_wea", rxWea[i], 3'b001 << ctype);
      end
   endtask

   // Main sequence: reset values, command table, reset abort, back-to-back commands.
   initial begin
      int waited;
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_tag = '0;
      cmd_type = '0;
      cmd_addr = '0;
      cmd_len = '0;
      Ready_from_Bus = 1'b1;
      for (int i = 0; i < 1024; i++) mem[i] = DATA_W'(i + 1);

      vecs[0] = '{6'd30, 2'd0, 10'd0,    8'd5,  MODE_FULL,  7,  1'b0};
      vecs[1] = '{6'd33, 2'd1, 10'd1020, 8'd35, MODE_RAND,  -1, 1'b0};
      vecs[2] = '{6'd12, 2'd2, 10'd0,    8'd0,  MODE_FULL,  0,  1'b0};
      vecs[3] = '{6'd7,  2'd3, 10'd100,  8'd4,  MODE_FULL,  0,  1'b1};
      vecs[4] = '{6'd45, 2'd2, 10'd500,  8'd10, MODE_STALL, 32, 1'b0};
      vecs[5] = '{6'd63, 2'd0, 10'd1023, 8'd3,  MODE_FULL,  5,  1'b0};
      vecs[6] = '{6'd1,  2'd1, 10'd200,  8'd1,  MODE_FULL,  3,  1'b0};

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_cmd_ready", cmd_ready, 1);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_err", err, 0);
      checkOutput("reset_buf_en", buf_en, 0);
      checkOutput("reset_buf_addr", buf_addr, 0);
      checkOutput("reset_enable", Enable_to_Bus, 0);
      checkOutput("reset_wea", weaBits, 0);
      checkOutput("reset_tag", Tag_to_Bus, 0);
      checkOutput("reset_value", value_to_Bus, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int v = 0; v < 7; v++) begin
         applyStimulus(vecs[v].tag, vecs[v].ctype, vecs[v].addr, vecs[v].len, 1'b0, waited);
         checkTransfer(vecs[v].tag, vecs[v].ctype, vecs[v].addr, vecs[v].len,
                       vecs[v].mode, vecs[v].expDoneAt, vecs[v].expErr);
      end

      applyStimulus(6'd20, 2'd0, 10'd300, 8'd10, 1'b0, waited);
      for (int t = 0; t < 4; t++) begin
         @(posedge clk);
         #1;
      end
      checkOutput("pre_reset_enable", Enable_to_Bus, 1);
      checkOutput("pre_reset_word3", value_to_Bus, 303);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("abort_enable", Enable_to_Bus, 0);
      checkOutput("abort_buf_en", buf_en, 0);
      checkOutput("abort_buf_addr", buf_addr, 0);
      checkOutput("abort_value", value_to_Bus, 0);
      checkOutput("abort_tag", Tag_to_Bus, 0);
      checkOutput("abort_wea", weaBits, 0);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_done", done, 0);
      checkOutput("abort_cmd_ready", cmd_ready, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(6'd9, 2'd2, 10'd40, 8'd2, 1'b0, waited);
      checkTransfer(6'd9, 2'd2, 10'd40, 8'd2, MODE_FULL, 4, 1'b0);

      applyStimulus(6'd5, 2'd1, 10'd600, 8'd4, 1'b1, waited);
      cmd_tag = 6'd50;
      cmd_type = 2'd0;
      cmd_addr = 10'd700;
      cmd_len = 8'd3;
      checkTransfer(6'd5, 2'd1, 10'd600, 8'd4, MODE_FULL, 6, 1'b0);
      applyStimulus(6'd50, 2'd0, 10'd700, 8'd3, 1'b0, waited);
      checkOutput("b2b_accept_wait", waited, 0);
      checkTransfer(6'd50, 2'd0, 10'd700, 8'd3, MODE_FULL, 5, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
